// File: rtl/periodic_event_scheduler_pkg.sv
// Shared definitions for the periodic event scheduler: default sizing and
// the encoding of the event-offer state machine.
package periodic_event_scheduler_pkg;

   localparam int NCH_DEF = 4;
   localparam int PW_DEF  = 16;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_OFFER = 1'b1
   } sched_state_e;

endpackage

// File: rtl/periodic_event_scheduler_if.sv
// Event handshake bundle: the scheduler offers (valid, ch) and the
// consumer answers with ready. The offer is held until it is accepted.
interface periodic_event_scheduler_if #(
   parameter int CW = 2
) ();

   logic          ev_valid;
   logic [CW-1:0] ev_ch;
   logic          ev_ready;

   modport master (output ev_valid, output ev_ch, input ev_ready);
   modport slave  (input ev_valid, input ev_ch, output ev_ready);

endinterface

// File: rtl/periodic_event_scheduler_rr_arbiter.sv
// Round-robin picker: returns the first requesting index found by scanning
// upward from ptr and wrapping past NCH-1.
module rr_arbiter #(
   parameter int NCH = 4,
   parameter int CW  = 2
) (
   input  logic [NCH-1:0] req,
   input  logic [CW-1:0]  ptr,
   output logic [CW-1:0]  grant,
   output logic           any
);

   // Scan offsets from farthest to nearest so the nearest requester wins last.
   always_comb begin
      grant = '0;
      any   = 1'b0;
      for (int k = NCH - 1; k >= 0; k--) begin
         if (req[(int'(ptr) + k) % NCH]) begin
            grant = CW'((int'(ptr) + k) % NCH);
            any   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/periodic_event_scheduler.sv
// Periodic event scheduler: NCH channels, each firing every period[i] ticks.
// Expiries are registered once before they reach the pending flags, so an
// offer appears on the second edge after the tick that expired the channel.
//
//   state    | meaning
//   ST_IDLE  | no offer on the bus; pick the next pending channel if any
//   ST_OFFER | ev_valid high, ev_ch frozen until ev_ready is seen
module periodic_event_scheduler
   import periodic_event_scheduler_pkg::*;
#(
   parameter int NCH = NCH_DEF,
   parameter int PW  = PW_DEF,
   parameter int CW  = $clog2(NCH)
) (
   input  logic                clk_in,
   input  logic                rst_n,
   input  logic                tick,
   input  logic [NCH-1:0]      ch_en,
   input  logic                cfg_we,
   input  logic [CW-1:0]       cfg_ch,
   input  logic [PW-1:0]       cfg_period,
   output logic [NCH-1:0]      overrun,
   input  logic [NCH-1:0]      overrun_clr,
   periodic_event_scheduler_if.master ev_if
);

   logic [NCH-1:0][PW-1:0] period_q, period_d;
   logic [NCH-1:0][PW-1:0] cnt_q, cnt_d;
   logic [NCH-1:0]         exp_q, exp_d;
   logic [NCH-1:0]         pending_q, pending_d;
   logic [NCH-1:0]         overrun_q, overrun_d;
   logic [NCH-1:0]         ack;

   sched_state_e           state_q;
   logic                   ev_valid_q;
   logic [CW-1:0]          ev_ch_q;
   logic [CW-1:0]          rr_q;

   logic [CW-1:0]          arb_grant;
   logic                   arb_any;

   function automatic logic [CW-1:0] next_ptr(input logic [CW-1:0] ch);
      return (ch == CW'(NCH - 1)) ? '0 : ch + CW'(1);
   endfunction

   // Per-channel timers; a config write wins over the tick update and
   // suppresses any expiry of the written channel on that edge.
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         period_d[i] = period_q[i];
         cnt_d[i]    = cnt_q[i];
         exp_d[i]    = 1'b0;
         if (!ch_en[i] || (period_q[i] == '0)) begin
            cnt_d[i] = '0;
         end else if (tick) begin
            if (cnt_q[i] == period_q[i] - PW'(1)) begin
               cnt_d[i] = '0;
               exp_d[i] = 1'b1;
            end else begin
               cnt_d[i] = cnt_q[i] + PW'(1);
            end
         end
         if (cfg_we && (cfg_ch == CW'(i))) begin
            period_d[i] = cfg_period;
            cnt_d[i]    = '0;
            exp_d[i]    = 1'b0;
         end
      end
   end

   // Pending/overrun bookkeeping; a fresh expiry beats both the handshake
   // clear of pending and the software clear of overrun.
   always_comb begin
      ack = '0;
      if (ev_valid_q && ev_if.ev_ready) ack[ev_ch_q] = 1'b1;
      pending_d = pending_q;
      overrun_d = overrun_q;
      for (int i = 0; i < NCH; i++) begin
         if (ack[i]) pending_d[i] = 1'b0;
         if (overrun_clr[i]) overrun_d[i] = 1'b0;
         if (exp_q[i]) begin
            if (pending_q[i] && !ack[i]) overrun_d[i] = 1'b1;
            pending_d[i] = 1'b1;
         end
      end
   end

   // Channel state registers.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         period_q  <= '0;
         cnt_q     <= '0;
         exp_q     <= '0;
         pending_q <= '0;
         overrun_q <= '0;
      end else begin
         period_q  <= period_d;
         cnt_q     <= cnt_d;
         exp_q     <= exp_d;
         pending_q <= pending_d;
         overrun_q <= overrun_d;
      end
   end

   rr_arbiter #(
      .NCH (NCH),
      .CW  (CW)
   ) u_rr_arbiter (
      .req   (pending_q),
      .ptr   (rr_q),
      .grant (arb_grant),
      .any   (arb_any)
   );

   // Offer FSM with registered valid/channel outputs.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         ev_valid_q <= 1'b0;
         ev_ch_q    <= '0;
         rr_q       <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (arb_any) begin
                  ev_ch_q    <= arb_grant;
                  ev_valid_q <= 1'b1;
                  state_q    <= ST_OFFER;
               end
            end
            ST_OFFER: begin
               if (ev_if.ev_ready) begin
                  ev_valid_q <= 1'b0;
                  rr_q       <= next_ptr(ev_ch_q);
                  state_q    <= ST_IDLE;
               end
            end
            default: begin
               ev_valid_q <= 1'b0;
               state_q    <= ST_IDLE;
            end
         endcase
      end
   end

   assign ev_if.ev_valid = ev_valid_q;
   assign ev_if.ev_ch    = ev_ch_q;
   assign overrun        = overrun_q;

endmodule

// File: tb/tb_periodic_event_scheduler.sv
// Directed bench for the periodic event scheduler. Inputs change 1 ns after
// each rising edge and outputs are sampled at the same point.
module tb_periodic_event_scheduler;

   localparam int NCH = 4;
   localparam int PW  = 16;
   localparam int CW  = 2;

   logic           clk_in;
   logic           rst_n;
   logic           tick;
   logic [NCH-1:0] ch_en;
   logic           cfg_we;
   logic [CW-1:0]  cfg_ch;
   logic [PW-1:0]  cfg_period;
   logic [NCH-1:0] overrun;
   logic [NCH-1:0] overrun_clr;

   int vec;
   int errs;

   periodic_event_scheduler_if #(.CW(CW)) ev_if ();

   periodic_event_scheduler #(
      .NCH (NCH),
      .PW  (PW),
      .CW  (CW)
   ) dut (
      .clk_in      (clk_in),
      .rst_n       (rst_n),
      .tick        (tick),
      .ch_en       (ch_en),
      .cfg_we      (cfg_we),
      .cfg_ch      (cfg_ch),
      .cfg_period  (cfg_period),
      .overrun     (overrun),
      .overrun_clr (overrun_clr),
      .ev_if       (ev_if.master)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_in);
         #1;
      end
   endtask

   task automatic do_reset();
      tick            = 1'b0;
      ch_en           = '0;
      cfg_we          = 1'b0;
      cfg_ch          = '0;
      cfg_period      = '0;
      overrun_clr     = '0;
      ev_if.ev_ready  = 1'b0;
      rst_n           = 1'b0;
      #2;
      rst_n           = 1'b1;
      cyc(1);
   endtask

   task automatic cfg_write(input logic [CW-1:0] ch, input logic [PW-1:0] per);
      cfg_we     = 1'b1;
      cfg_ch     = ch;
      cfg_period = per;
      cyc(1);
      cfg_we     = 1'b0;
   endtask

   task automatic test_reset();
      rst_n          = 1'b0;
      tick           = 1'b0;
      ch_en          = '0;
      cfg_we         = 1'b0;
      cfg_ch         = '0;
      cfg_period     = '0;
      overrun_clr    = '0;
      ev_if.ev_ready = 1'b0;
      cyc(2);
      vec++;
      if (ev_if.ev_valid !== 1'b0 || ev_if.ev_ch !== 2'd0 || overrun !== 4'b0000) begin
         errs++;
         $display("FAIL reset: valid=%b ch=%0d overrun=%b, want 0/0/0000",
                  ev_if.ev_valid, ev_if.ev_ch, overrun);
      end
      rst_n = 1'b1;
      cyc(1);
   endtask

   // period 3 on ch0, tick every cycle: offers after edges 5, 8, 11
   task automatic test_periodic();
      logic exp_v;
      do_reset();
      cfg_write(2'd0, 16'd3);
      ch_en          = 4'b0001;
      ev_if.ev_ready = 1'b1;
      tick           = 1'b1;
      for (int n = 1; n <= 12; n++) begin
         cyc(1);
         exp_v = (n >= 5) && ((n - 5) % 3 == 0);
         vec++;
         if (ev_if.ev_valid !== exp_v || (exp_v && ev_if.ev_ch !== 2'd0)) begin
            errs++;
            $display("FAIL periodic edge %0d: valid=%b ch=%0d, want valid=%b ch=0",
                     n, ev_if.ev_valid, ev_if.ev_ch, exp_v);
         end
      end
      tick = 1'b0;
   endtask

   // all channels period 1, single tick: ch0..ch3 with one idle cycle between
   task automatic test_back_to_back();
      logic          exp_v;
      logic [CW-1:0] exp_c;
      do_reset();
      for (int c = 0; c < NCH; c++) cfg_write(CW'(c), 16'd1);
      ch_en          = 4'b1111;
      ev_if.ev_ready = 1'b1;
      tick           = 1'b1;
      cyc(1);
      tick = 1'b0;
      for (int n = 1; n <= 11; n++) begin
         cyc(1);
         exp_v = (n % 2 == 0) && (n <= 8);
         exp_c = CW'((n - 2) / 2);
         vec++;
         if (ev_if.ev_valid !== exp_v || (exp_v && ev_if.ev_ch !== exp_c)) begin
            errs++;
            $display("FAIL back_to_back edge %0d: valid=%b ch=%0d, want valid=%b ch=%0d",
                     n, ev_if.ev_valid, ev_if.ev_ch, exp_v, exp_c);
         end
      end
      vec++;
      if (overrun !== 4'b0000) begin
         errs++;
         $display("FAIL back_to_back overrun: got %b want 0000", overrun);
      end
   endtask

   // stalled consumer on ch2: hold, overrun, clear, set-beats-clear
   task automatic test_overrun();
      do_reset();
      cfg_write(2'd2, 16'd1);
      ch_en          = 4'b0100;
      ev_if.ev_ready = 1'b0;
      tick           = 1'b1;
      cyc(3);
      tick = 1'b0;
      cyc(3);
      vec++;
      if (ev_if.ev_valid !== 1'b1 || ev_if.ev_ch !== 2'd2 || overrun !== 4'b0100) begin
         errs++;
         $display("FAIL overrun set: valid=%b ch=%0d overrun=%b, want 1/2/0100",
                  ev_if.ev_valid, ev_if.ev_ch, overrun);
      end
      cyc(3);
      vec++;
      if (ev_if.ev_valid !== 1'b1 || ev_if.ev_ch !== 2'd2) begin
         errs++;
         $display("FAIL offer hold: valid=%b ch=%0d, want 1/2", ev_if.ev_valid, ev_if.ev_ch);
      end
      overrun_clr = 4'b0100;
      cyc(1);
      overrun_clr = 4'b0000;
      vec++;
      if (overrun !== 4'b0000 || ev_if.ev_valid !== 1'b1) begin
         errs++;
         $display("FAIL overrun clear: overrun=%b valid=%b, want 0000/1", overrun, ev_if.ev_valid);
      end
      tick        = 1'b1;
      overrun_clr = 4'b0100;
      cyc(1);
      tick = 1'b0;
      cyc(1);
      overrun_clr = 4'b0000;
      vec++;
      if (overrun !== 4'b0100) begin
         errs++;
         $display("FAIL overrun set_wins: got %b want 0100", overrun);
      end
      ev_if.ev_ready = 1'b1;
      cyc(1);
      vec++;
      if (ev_if.ev_valid !== 1'b0) begin
         errs++;
         $display("FAIL overrun accept: valid=%b want 0", ev_if.ev_valid);
      end
      cyc(2);
      vec++;
      if (ev_if.ev_valid !== 1'b0) begin
         errs++;
         $display("FAIL overrun drained: valid=%b want 0", ev_if.ev_valid);
      end
   endtask

   // rewrite ch1 period to 5 after 3 ticks: event only after 5 further ticks
   task automatic test_reconfig();
      logic exp_v;
      do_reset();
      cfg_write(2'd1, 16'd8);
      ch_en          = 4'b0010;
      ev_if.ev_ready = 1'b1;
      tick           = 1'b1;
      cyc(3);
      cfg_write(2'd1, 16'd5);
      for (int n = 1; n <= 8; n++) begin
         cyc(1);
         exp_v = (n == 7);
         vec++;
         if (ev_if.ev_valid !== exp_v || (exp_v && ev_if.ev_ch !== 2'd1)) begin
            errs++;
            $display("FAIL reconfig edge %0d: valid=%b ch=%0d, want valid=%b ch=1",
                     n, ev_if.ev_valid, ev_if.ev_ch, exp_v);
         end
      end
      tick = 1'b0;
   endtask

   // asynchronous reset while an offer is up
   task automatic test_reset_mid_offer();
      do_reset();
      cfg_write(2'd3, 16'd1);
      ch_en          = 4'b1000;
      ev_if.ev_ready = 1'b0;
      tick           = 1'b1;
      cyc(1);
      tick = 1'b0;
      cyc(2);
      vec++;
      if (ev_if.ev_valid !== 1'b1 || ev_if.ev_ch !== 2'd3) begin
         errs++;
         $display("FAIL pre_reset offer: valid=%b ch=%0d, want 1/3", ev_if.ev_valid, ev_if.ev_ch);
      end
      #2;
      rst_n = 1'b0;
      #1;
      vec++;
      if (ev_if.ev_valid !== 1'b0 || ev_if.ev_ch !== 2'd0 || overrun !== 4'b0000) begin
         errs++;
         $display("FAIL async reset: valid=%b ch=%0d overrun=%b, want 0/0/0000",
                  ev_if.ev_valid, ev_if.ev_ch, overrun);
      end
      #1;
      rst_n = 1'b1;
      tick  = 1'b1;
      cyc(6);
      tick = 1'b0;
      vec++;
      if (ev_if.ev_valid !== 1'b0) begin
         errs++;
         $display("FAIL post_reset quiet: valid=%b want 0", ev_if.ev_valid);
      end
   endtask

   // period 0 never fires
   task automatic test_period_zero();
      int seen;
      seen = 0;
      do_reset();
      cfg_write(2'd0, 16'd0);
      ch_en          = 4'b0001;
      ev_if.ev_ready = 1'b1;
      tick           = 1'b1;
      for (int n = 0; n < 100; n++) begin
         cyc(1);
         if (ev_if.ev_valid !== 1'b0) seen++;
      end
      tick = 1'b0;
      cyc(3);
      vec++;
      if (seen != 0 || overrun !== 4'b0000) begin
         errs++;
         $display("FAIL period_zero: %0d valid cycles overrun=%b, want 0/0000", seen, overrun);
      end
   endtask

   initial begin
      vec  = 0;
      errs = 0;
      test_reset();
      test_periodic();
      test_back_to_back();
      test_overrun();
      test_reconfig();
      test_reset_mid_offer();
      test_period_zero();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
